// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits, optional parity, 1/2 stop bits, 8..32x oversampling).
// Latency: word valid on the last stop bit's decision tick, (frame_bits-1)*OVERSAMPLE + M + 1 ticks after start entry.
// Backpressure: single holding register; a frame completing while the held word is not accepted is dropped and sets overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] S_LO   = CW'(M - 1);
  localparam logic [CW-1:0] S_MID  = CW'(M);
  localparam logic [CW-1:0] S_HI   = CW'(M + 1);
  localparam logic [CW-1:0] S_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 frame_err;
    logic                 parity_err;
    logic                 brk;
  } word_t;

  state_t               state_q, state_d;
  logic                 rxd_m, rxd_s;
  logic                 armed_q;
  logic [CW-1:0]        scnt_q;
  logic [BW-1:0]        bcnt_q;
  logic                 v0_q, v1_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q, zero_q, ferr_q, perr_q, brk_q, stop2_q;
  logic                 at_dec, at_wrap, vote, last_stop, brk_now;
  logic                 start_go, done;
  word_t                hold_q, word_d;
  logic                 valid_q, overrun_q, busy_q;
  logic                 xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  assign at_dec    = i_clk_rx && (scnt_q == S_HI);
  assign at_wrap   = i_clk_rx && (scnt_q == S_LAST);
  assign vote      = (v0_q & v1_q) | (v0_q & rxd_s) | (v1_q & rxd_s);
  assign last_stop = (STOP_BITS == 1) || stop2_q;
  // With two stop bits the break decision was already latched on the first one.
  assign brk_now   = stop2_q ? brk_q : (zero_q & ~vote);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clk_rx && armed_q && !rxd_s) begin
          state_d  = START;
          start_go = 1'b1;
        end
      end
      START: begin
        if (at_dec && vote)  state_d = IDLE;
        else if (at_wrap)    state_d = DATA;
      end
      DATA: begin
        if (at_wrap && (bcnt_q == B_LAST)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        if (at_dec && last_stop) begin
          done    = 1'b1;
          state_d = brk_now ? WAIT_HIGH : IDLE;
        end
      end
      WAIT_HIGH: begin
        if (i_clk_rx && rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      v0_q    <= 1'b1;
      v1_q    <= 1'b1;
      shreg_q <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b1;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      if (i_clk_rx && rxd_s) armed_q <= 1'b1;
      if (i_clk_rx) begin
        // The detecting tick itself counts as sample 0 of the start bit.
        if (start_go)                scnt_q <= CW'(1);
        else if (scnt_q == S_LAST)   scnt_q <= '0;
        else                         scnt_q <= scnt_q + CW'(1);
        if (scnt_q == S_LO)  v0_q <= rxd_s;
        if (scnt_q == S_MID) v1_q <= rxd_s;
      end
      if (start_go) begin
        bcnt_q  <= '0;
        par_q   <= 1'b0;
        zero_q  <= 1'b1;
        ferr_q  <= 1'b0;
        perr_q  <= 1'b0;
        brk_q   <= 1'b0;
        stop2_q <= 1'b0;
      end
      if (at_dec) begin
        case (state_q)
          DATA: begin
            shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ vote;
            zero_q  <= zero_q & ~vote;
            bcnt_q  <= bcnt_q + BW'(1);
          end
          PARITY: begin
            perr_q <= vote ^ par_q ^ 1'(PARITY_ODD);
            zero_q <= zero_q & ~vote;
          end
          STOP: begin
            if (!vote)    ferr_q <= 1'b1;
            if (!stop2_q) brk_q  <= zero_q & ~vote;
          end
          default: ;
        endcase
      end
      if (at_wrap && (state_q == STOP) && !stop2_q) stop2_q <= 1'b1;
    end
  end

  always_comb begin
    word_d            = '0;
    word_d.data       = shreg_q;
    word_d.frame_err  = ferr_q | ~vote;
    word_d.parity_err = perr_q;
    word_d.brk        = brk_now;
  end

  assign xfer = valid_q & i_rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (done && (!valid_q || i_rx_ready)) begin
        hold_q  <= word_d;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (done && valid_q && !i_rx_ready) overrun_q <= 1'b1;
      else if (xfer)                      overrun_q <= 1'b0;
    end
  end

  assign o_rx_data    = hold_q.data;
  assign o_frame_err  = hold_q.frame_err;
  assign o_parity_err = hold_q.parity_err;
  assign o_break      = hold_q.brk;
  assign o_rx_valid   = valid_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = busy_q;

endmodule
